// File: rtl/dpsram_param.sv
// True dual-port SRAM with byte enables, read-first ports, collision flag and a post-reset clear sequencer.
// Define DPSRAM_OUTREG_EN to add an output register stage on douta/doutb/coll (read latency 2).
module dpsram_param #(
  parameter int DW    = 128,
  parameter int AW    = 11,
  parameter int DEPTH = 2**AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic [DW/8-1:0] wea,
  input  logic [AW-1:0]   addra,
  input  logic [DW-1:0]   dina,
  output logic [DW-1:0]   douta,
  input  logic            enb,
  input  logic [DW/8-1:0] web,
  input  logic [AW-1:0]   addrb,
  input  logic [DW-1:0]   dinb,
  output logic [DW-1:0]   doutb,
  output logic            init_done,
  output logic            coll
);

  localparam int          NB      = DW / 8;
  localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic {CLEAR, READY} state_e;

  state_e          state_q, state_d;
  logic [AW:0]     clr_cnt_q, clr_cnt_d;
  logic [DW-1:0]   douta_q, douta_d, doutb_q, doutb_d;
  logic            coll_q, coll_d;

  logic [DW-1:0]   mem [DEPTH];

  logic            a_in, b_in, a_wr, b_wr, clr_wr;
  logic [IW-1:0]   a_idx, b_idx, clr_idx;
  logic [DW-1:0]   mask_a, mask_b, a_base, a_wdata, b_wdata;

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      mask_a[i*8 +: 8] = {8{wea[i]}};
      mask_b[i*8 +: 8] = {8{web[i]}};
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    douta_d   = douta_q;
    doutb_d   = doutb_q;
    coll_d    = 1'b0;
    clr_wr    = 1'b0;
    a_wr      = 1'b0;
    b_wr      = 1'b0;
    a_in      = ({1'b0, addra} < DEPTH_W);
    b_in      = ({1'b0, addrb} < DEPTH_W);
    a_idx     = addra[IW-1:0];
    b_idx     = addrb[IW-1:0];
    clr_idx   = clr_cnt_q[IW-1:0];
    case (state_q)
      CLEAR: begin
        douta_d = '0;
        doutb_d = '0;
        // One extra CLEAR cycle after the last word so init_done lands on edge DEPTH+1.
        if (clr_cnt_q < DEPTH_W) begin
          clr_wr    = 1'b1;
          clr_cnt_d = clr_cnt_q + (AW+1)'(1);
        end else begin
          state_d = READY;
        end
      end
      READY: begin
        a_wr = ena && a_in && (wea != '0);
        b_wr = enb && b_in && (web != '0);
        if (ena) douta_d = a_in ? mem[a_idx] : '0;
        if (enb) doutb_d = b_in ? mem[b_idx] : '0;
        coll_d = ena && enb && (addra == addrb) && ((wea != '0) || (web != '0));
      end
      default: state_d = CLEAR;
    endcase
  end

  // Port A's word is merged on top of port B's so A wins shared lanes on a same-address write.
  always_comb begin
    b_wdata = (mem[b_idx] & ~mask_b) | (dinb & mask_b);
    a_base  = (b_wr && (addra == addrb)) ? b_wdata : mem[a_idx];
    a_wdata = (a_base & ~mask_a) | (dina & mask_a);
  end

  always_ff @(posedge clk) begin
    if (clr_wr) begin
      mem[clr_idx] <= '0;
    end else begin
      if (b_wr) mem[b_idx] <= b_wdata;
      if (a_wr) mem[a_idx] <= a_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      douta_q   <= '0;
      doutb_q   <= '0;
      coll_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      douta_q   <= douta_d;
      doutb_q   <= doutb_d;
      coll_q    <= coll_d;
    end
  end

  assign init_done = (state_q == READY);

`ifdef DPSRAM_OUTREG_EN
  logic [DW-1:0] douta_o_q, douta_o_d, doutb_o_q, doutb_o_d;
  logic          coll_o_q, coll_o_d;

  always_comb begin
    douta_o_d = douta_q;
    doutb_o_d = doutb_q;
    coll_o_d  = coll_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      douta_o_q <= '0;
      doutb_o_q <= '0;
      coll_o_q  <= 1'b0;
    end else begin
      douta_o_q <= douta_o_d;
      doutb_o_q <= doutb_o_d;
      coll_o_q  <= coll_o_d;
    end
  end

  assign douta = douta_o_q;
  assign doutb = doutb_o_q;
  assign coll  = coll_o_q;
`else
  assign douta = douta_q;
  assign doutb = doutb_q;
  assign coll  = coll_q;
`endif

endmodule

// File: tb/tb_dpsram_param.sv
// Randomized + directed bench for dpsram_param against a word-array reference model.
module tb_dpsram_param;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 24;
  localparam int NB    = DW / 8;
`ifdef DPSRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk, rst;
  logic          ena, enb;
  logic [NB-1:0] wea, web;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] dina, dinb, douta, doutb;
  logic          init_done, coll;

  dpsram_param #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb),
    .init_done(init_done), .coll(coll)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model + scoreboard
  logic [DW-1:0]     ref_mem [DEPTH];
  logic [DW-1:0]     ref_a, ref_b;
  int                cyc;
  logic [2*DW:0]     exp_q[$];
  int                n_vec, n_fail;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_a = '0;
    ref_b = '0;
    cyc   = 0;
    exp_q.delete();
    for (int i = 0; i < LAT - 1; i++) exp_q.push_back('0);
  endtask

  // Called right after a rising edge while the inputs of the finished cycle are still applied.
  task automatic model_step();
    logic       ready;
    logic       nc;
    logic [DW-1:0] w;
    ready = (cyc >= DEPTH + 1);
    nc    = 1'b0;
    if (!ready) begin
      ref_a = '0;
      ref_b = '0;
    end else begin
      if (ena) ref_a = (int'(addra) < DEPTH) ? ref_mem[addra] : '0;
      if (enb) ref_b = (int'(addrb) < DEPTH) ? ref_mem[addrb] : '0;
      nc = ena && enb && (addra == addrb) && ((wea != 0) || (web != 0));
      if (enb && int'(addrb) < DEPTH) begin
        w = ref_mem[addrb];
        for (int i = 0; i < NB; i++) if (web[i]) w[i*8 +: 8] = dinb[i*8 +: 8];
        ref_mem[addrb] = w;
      end
      if (ena && int'(addra) < DEPTH) begin
        w = ref_mem[addra];
        for (int i = 0; i < NB; i++) if (wea[i]) w[i*8 +: 8] = dina[i*8 +: 8];
        ref_mem[addra] = w;
      end
    end
    exp_q.push_back({nc, ref_b, ref_a});
    cyc++;
  endtask

  task automatic check_outputs();
    logic [2*DW:0] e;
    e = exp_q.pop_front();
    check("douta", douta, e[DW-1:0]);
    check("doutb", doutb, e[2*DW-1:DW]);
    check("coll", coll, e[2*DW]);
    check("init_done", init_done, cyc >= DEPTH + 1);
  endtask

  // driver: one clock of stimulus, called from a falling edge
  task automatic do_cycle(input logic a_en, input logic [NB-1:0] a_we, input logic [AW-1:0] a_ad,
                          input logic [DW-1:0] a_d, input logic b_en, input logic [NB-1:0] b_we,
                          input logic [AW-1:0] b_ad, input logic [DW-1:0] b_d);
    ena = a_en; wea = a_we; addra = a_ad; dina = a_d;
    enb = b_en; web = b_we; addrb = b_ad; dinb = b_d;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    do_cycle(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic settle();
    for (int i = 0; i < LAT - 1; i++) idle();
  endtask

  int rise;

  initial begin
    n_vec = 0;
    n_fail = 0;
    rst = 1'b1;
    ena = 1'b0; wea = '0; addra = '0; dina = '0;
    enb = 1'b0; web = '0; addrb = '0; dinb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_douta", douta, 0);
    check("rst_doutb", doutb, 0);
    check("rst_coll", coll, 0);
    check("rst_init_done", init_done, 0);
    rst = 1'b0;
    model_reset();

    // Writes during the clear sequence must be lost.
    rise = -1;
    for (int i = 0; i <= DEPTH; i++) begin
      do_cycle(1'b1, NB'($urandom), AW'($urandom), DW'($urandom),
               1'b1, NB'($urandom), AW'($urandom), DW'($urandom));
      if (init_done && rise < 0) rise = cyc;
    end
    for (int i = 0; i < 5 && rise < 0; i++) begin
      idle();
      if (init_done) rise = cyc;
    end
    check("init_rise_cycle", rise, DEPTH + 1);

    for (int i = 0; i < 2**AW; i++)
      do_cycle(1'b1, '0, AW'(i), '0, 1'b1, '0, AW'(2**AW - 1 - i), '0);
    idle();

    // byte-enable merge
    do_cycle(1'b1, '1, 5'd5, 32'hFFFF_FFFF, 1'b0, '0, '0, '0);
    do_cycle(1'b0, '0, '0, '0, 1'b1, 4'b0001, 5'd5, 32'h0000_00AA);
    do_cycle(1'b1, '0, 5'd5, '0, 1'b0, '0, '0, '0);
    settle();
    check("be_read", douta, 32'hFFFF_FFAA);

    // read-first with collision
    do_cycle(1'b1, '1, 5'd9, 32'h11, 1'b0, '0, '0, '0);
    do_cycle(1'b1, '1, 5'd9, 32'h22, 1'b1, '0, 5'd9, '0);
    settle();
    check("rf_doutb", doutb, 32'h11);
    check("rf_coll", coll, 1);
    do_cycle(1'b0, '0, '0, '0, 1'b1, '0, 5'd9, '0);
    settle();
    check("rf_after", doutb, 32'h22);

    // write-write collision, A wins
    do_cycle(1'b1, '1, 5'd3, 32'h33, 1'b1, '1, 5'd3, 32'h44);
    settle();
    check("ww_coll", coll, 1);
    idle();
    check("ww_coll_low", coll, 0);
    do_cycle(1'b1, '0, 5'd3, '0, 1'b0, '0, '0, '0);
    settle();
    check("ww_read", douta, 32'h33);

    // randomized traffic, biased toward shared addresses and out-of-range words
    for (int i = 0; i < 600; i++) begin
      logic [AW-1:0] aa, ab;
      aa = AW'($urandom_range(0, 2**AW - 1));
      ab = ($urandom_range(0, 3) == 0) ? aa : AW'($urandom_range(0, 2**AW - 1));
      do_cycle(1'($urandom), ($urandom_range(0, 1) == 0) ? '0 : NB'($urandom), aa, DW'($urandom),
               1'($urandom), ($urandom_range(0, 1) == 0) ? '0 : NB'($urandom), ab, DW'($urandom));
    end

    // mid-operation asynchronous reset
    do_cycle(1'b1, '1, 5'd0, 32'h55, 1'b0, '0, '0, '0);
    do_cycle(1'b1, '0, 5'd0, '0, 1'b1, '0, 5'd0, '0);
    settle();
    check("pre_rst_douta", douta, 32'h55);
    #2 rst = 1'b1;
    #1;
    check("async_douta", douta, 0);
    check("async_doutb", doutb, 0);
    check("async_init_done", init_done, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i <= DEPTH; i++) idle();
    check("reclear_init", init_done, 1);
    do_cycle(1'b1, '0, 5'd0, '0, 1'b1, '0, 5'd0, '0);
    settle();
    check("reclear_addr0", douta, 0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/dpsram_param.md
# dpsram_param

Parametrised true dual-port SRAM model for packet-buffer and descriptor storage, succeeding the fixed 128-bit × 2K black-box macros. Both ports run on a single clock. Each port provides:
- byte-enable writes
- read-first semantics
- an address-collision flag

A built-in clear sequencer zeroes the array after reset. The block synthesises to inferred RAM and also serves as the simulation model wherever a vendor macro is absent.

## Interface
Parameters:
- DW, 128, data width in bits; must be a multiple of 8
- AW, 11, address width
- DEPTH, 2**AW, number of words; DEPTH ≤ 2**AW

Ports:
- clk  input  1  sole clock for both ports
- rst  input  1  asynchronous, active-high reset
- ena  input  1  port A enable
- wea  input  DW/8  port A byte write enables; 0 = read
- addra  input  AW  port A address
- dina  input  DW  port A write data
- douta  output  DW  port A read data
- enb  input  1  port B enable
- web  input  DW/8  port B byte write enables; 0 = read
- addrb  input  AW  port B address
- dinb  input  DW  port B write data
- doutb  output  DW  port B read data
- init_done  output  1  high once the clear sequence has finished
- coll  output  1  one-cycle pulse on a same-address access conflict

Decided: one clock; reset is asynchronous and active-high.

## Operation
- FSM states are CLEAR and READY. rst forces CLEAR with clr_cnt = 0.
- CLEAR:
  - Writes zero to word clr_cnt each cycle and increments clr_cnt.
  - After writing DEPTH−1, moves to READY on the next edge.
  - ena and enb are ignored; douta, doutb and coll are held at 0.
- READY:
  - Port X with enX = 1 and weX ≠ 0 writes dinX byte lanes where weX[i] = 1; other lanes are unchanged.
  - Port X with enX = 1 reads word addrX. Reads are read-first: a same-cycle write to that word by either port does not affect the returned data.
  - enX = 0: doutX holds its previous value.
- Address ≥ DEPTH: writes are dropped and reads return 0.
- Both ports enabled, addra == addrb, and at least one port writing:
  - coll pulses the next cycle.
  - Write-write overlap: on lanes enabled by both ports, port A data wins. On lanes enabled by only one port, that port's data is written.
  - Both ports reading the same address is not a collision.
- rst during READY returns the FSM to CLEAR. Array contents are re-cleared from address 0.

## Timing
- Clear takes DEPTH cycles. init_done rises on the first READY cycle: the edge DEPTH+1 after rst deasserts.
- Read latency is 1 cycle: doutX is valid the cycle after the enabled access.
- Writes are visible to reads issued on the following cycle.
- coll is registered; it is high in the same cycle as the read data of the colliding access.
- Reset values: douta = 0, doutb = 0, coll = 0, init_done = 0, FSM in CLEAR.
- Accesses presented in the cycle init_done first rises are serviced.

## Configuration
- DPSRAM_OUTREG_EN defined:
  - Adds an output register stage on douta, doutb and coll; read latency becomes 2.
  - The stage advances every cycle regardless of enX.
  - Stage registers reset to 0.
- Undefined: 1-cycle latency as above.

## Test plan
- Reset clear: release rst and read every address after init_done → init_done rises at cycle DEPTH+1; every read returns 0; any write before init_done is lost.
- Byte-enable write: write 0xFF…FF to addr 5 via port A, then port B writes 0x00…AA with web = 0x0001 → next port A read of addr 5 returns 0xFF…FFAA.
- Read-first: addr 9 holds 0x11; same cycle, port A writes 0x22 and port B reads addr 9 → doutb = 0x11 and coll = 1 next cycle; the following read returns 0x22.
- Write-write collision: A writes 0x33 (all lanes) and B writes 0x44 (all lanes) to addr 3 → readback 0x33, coll pulses for exactly 1 cycle.
- Mid-operation reset: write 0x55 to addr 0, assert rst for 1 cycle → outputs are 0 immediately (asynchronous); after the new clear, addr 0 reads 0.
- With DPSRAM_OUTREG_EN: repeat the read-first case → doutb = 0x11 two cycles after the access; coll is aligned with it.
